gate_bist_ctrl: RTL and testbench

//   Built-in self-test sequencer for a 2-input basic gate (AND/OR/XOR/XNOR...).
//   On start it sweeps {A,B} through 00,01,10,11, waits a settle window, samples
//   the gate output, and compares it against a 4-bit expected truth table.
//   It reports pass/fail, a saturating error count and a sticky per-vector fail
//   map. It sits between the test/control logic and one gate instance.

---
 rtl/gate_bist_ctrl.sv | 151 +++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - BIST sequencer that sweeps a 2-input gate through all
// four input vectors and checks its output against a latched truth table.
module gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       truth_tbl,
  input  logic             gate_out,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PI_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PI_W-1:0]  pass_idx_q, pass_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tbl_q, tbl_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      pass_idx_q <= '0;
      cnt_q      <= '0;
      tbl_q      <= '0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_idx_q <= pass_idx_d;
      cnt_q      <= cnt_d;
      tbl_q      <= tbl_d;
      gate_a_q   <= gate_a_d;
      gate_b_q   <= gate_b_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  // Gate inputs are updated on the edge entering DRIVE so they are stable
  // for the whole DRIVE..SAMPLE window of each vector.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_idx_d = pass_idx_q;
    cnt_d      = cnt_q;
    tbl_d      = tbl_q;
    gate_a_d   = gate_a_q;
    gate_b_d   = gate_b_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;

    case (state_q)
      ST_IDLE: begin
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
        if (start) begin
          tbl_d      = truth_tbl;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          vec_d      = 2'd0;
          pass_idx_d = '0;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (gate_out != tbl_q[vec_q]) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          fail_d[vec_q] = 1'b1;
        end
        if (vec_q != 2'd3) begin
          vec_d    = vec_q + 2'd1;
          gate_a_d = vec_d[1];
          gate_b_d = vec_d[0];
          state_d  = ST_DRIVE;
        end else if (pass_idx_q < PI_W'(PASSES - 1)) begin
          vec_d      = 2'd0;
          pass_idx_d = pass_idx_q + 1'b1;
          gate_a_d   = 1'b0;
          gate_b_d   = 1'b0;
          state_d    = ST_DRIVE;
        end else begin
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        pass_d   = (err_q == '0);
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb/tb_gate_bist_ctrl.sv - directed bench for gate_bist_ctrl across four
// parameterisations driven in lockstep.
module tb_gate_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] tbl  [4];
  logic [1:0] mode [4];
  logic       ga   [4];
  logic       gb   [4];
  logic       gout [4];
  logic       busy [4];
  logic       done [4];
  logic       pass [4];
  logic [3:0] fv   [4];
  logic [3:0] err  [4];
  logic [3:0] err0, err1, err3;
  logic [1:0] err2;

  int checks   = 0;
  int failures = 0;
  int lat   [4];
  int dones [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0 = XNOR gate, 1 = stuck-at-1, 2 = stuck-at-0
  for (genvar g = 0; g < 4; g++) begin : g_gate
    assign gout[g] = (mode[g] == 2'd0) ? ~(ga[g] ^ gb[g]) : (mode[g] == 2'd1);
  end

  assign err[0] = err0;
  assign err[1] = err1;
  assign err[2] = {2'b00, err2};
  assign err[3] = err3;

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(tbl[0]), .gate_out(gout[0]),
    .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err0), .fail_vec(fv[0]));

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(4)) u_p2 (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(tbl[1]), .gate_out(gout[1]),
    .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err1), .fail_vec(fv[1]));

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(tbl[2]), .gate_out(gout[2]),
    .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err2), .fail_vec(fv[2]));

  gate_bist_ctrl #(.SETTLE_CYCLES(0), .PASSES(1), .ERR_W(4)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(tbl[3]), .gate_out(gout[3]),
    .gate_a(ga[3]), .gate_b(gb[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .err_cnt(err3), .fail_vec(fv[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start before edge k; j counts edges from k (j=0 is edge k).
  task automatic run(input int repulse_at, input int maxc);
    for (int i = 0; i < 4; i++) begin
      lat[i]   = -1;
      dones[i] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < maxc; j++) begin
      @(posedge clk);
      #1;
      start = (j == repulse_at);
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          dones[i]++;
          if (lat[i] < 0) lat[i] = j;
        end
      end
      if (j == 1) chk("pass_cleared_at_start", pass[0], 0);
      if (j < 16 && (j % 4) == 2) chk("vec_ab", {ga[0], gb[0]}, j / 4);
      if (j < 16 && (j % 4) == 0) chk("vec_ab_drive", {ga[0], gb[0]}, j / 4);
      if (j == 8 || j == 17) chk("busy_window", busy[0], (j < 17));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    tbl[0] = 4'b1001; mode[0] = 2'd0;
    tbl[1] = 4'b1001; mode[1] = 2'd1;
    tbl[2] = 4'b1111; mode[2] = 2'd2;
    tbl[3] = 4'b1001; mode[3] = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_err", err[1], 0);
    chk("rst_fail_vec", fv[1], 0);
    chk("rst_ab", {ga[0], gb[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // run 1: re-pulse start while busy
    run(3, 40);
    chk("xnor_lat", lat[0], 17);
    chk("xnor_pass", pass[0], 1);
    chk("xnor_err", err[0], 0);
    chk("xnor_fv", fv[0], 0);
    chk("xnor_dones", dones[0], 1);
    chk("stuck1_lat", lat[1], 33);
    chk("stuck1_err", err[1], 4);
    chk("stuck1_fv", fv[1], 4'b0110);
    chk("stuck1_pass", pass[1], 0);
    chk("sat_err", err[2], 3);
    chk("sat_fv", fv[2], 4'b1111);
    chk("sat_pass", pass[2], 0);
    chk("s0_lat", lat[3], 9);
    chk("s0_dones", dones[3], 1);
    chk("s0_pass", pass[3], 1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_err", err[1], 4);
    chk("hold_fv", fv[1], 4'b0110);
    chk("hold_pass", pass[0], 1);

    // run 2: previously failing unit now has a good gate
    mode[1] = 2'd0;
    run(-1, 40);
    chk("rerun_lat", lat[1], 33);
    chk("rerun_err", err[1], 0);
    chk("rerun_fv", fv[1], 0);
    chk("rerun_pass", pass[1], 1);
    chk("rerun_xnor_pass", pass[0], 1);

    // reset mid-run
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("mid_err_before_rst", err[2], 1);
    chk("mid_busy_before_rst", busy[2], 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy[2], 0);
    chk("mid_rst_ab", {ga[1], gb[1]}, 0);
    chk("mid_rst_err", err[2], 0);
    chk("mid_rst_done", done[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int j = 0; j < 40; j++) begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (done[i] || busy[i]) seen++;
      end
      chk("no_done_after_abort", seen, 0);
    end

    // run 3: normal run after abort
    run(-1, 40);
    chk("post_rst_lat", lat[0], 17);
    chk("post_rst_pass", pass[0], 1);
    chk("post_rst_dones", dones[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
